// File: rtl/mxu_result_collector.sv
// ---------------------------------------------------------------------------
// mxu_result_collector
//
// Output side of the MXU systolic core. The per-row result lanes leave the
// last array column skewed by one cycle per row. This block realigns them into
// whole vectors, buffers them in a small FIFO and presents them downstream
// over a valid/ready handshake. It requests an upstream stall early enough
// that vectors still inside the skew pipeline always find room. It pulses
// `done` once the programmed number of vectors has been delivered.
//
// Ports
//   clk          single rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle job start pulse (honoured only while idle)
//   num_vectors  number of result vectors in the job
//   y / y_valid  skewed result lanes; y_valid marks lane 0 of a vector
//   out_data     realigned vector at the FIFO head (0 while empty)
//   out_valid    FIFO non-empty
//   out_ready    downstream accepts the head entry
//   out_last     head entry is the final vector of the job
//   stall_req    upstream must stop issuing vectors into the core
//   busy         job in progress
//   done         one-cycle pulse at job end
//   overflow     sticky: a vector was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module mxu_result_collector #(
    parameter int M              = 3,
    parameter int max_data_width = 4,
    parameter int DEPTH          = 8,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_vectors,
    input  logic [M*max_data_width-1:0] y,
    input  logic                        y_valid,
    output logic [M*max_data_width-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        stall_req,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int LW = max_data_width;
    localparam int VW = M * LW;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [OW-1:0] M_C     = OW'(M);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] nv_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic             overflow_q;
    logic             done_q;
    logic             busy_q;

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [OW-1:0]    count_q;
    logic [OW-1:0]    count_d;
    logic [VW:0]      mem_q [DEPTH];

    logic [VW-1:0]    aligned_word;
    logic             aligned_vld;
    logic             start_acc;

    assign start_acc = (state_q == S_IDLE) && start;

    // ---------------------------------------------------------------- deskew
    // Lane i is delayed M-1-i cycles so every lane of a vector lines up with
    // the last lane, which arrives M-1 cycles after lane 0.
    for (genvar i = 0; i < M; i++) begin : g_lane
        localparam int S = M - 1 - i;
        if (S == 0) begin : g_pass
            assign aligned_word[i*LW +: LW] = y[i*LW +: LW];
        end else begin : g_dly
            logic [LW-1:0] pipe_q [S];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < S; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= y[i*LW +: LW];
                    for (int k = 1; k < S; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign aligned_word[i*LW +: LW] = pipe_q[S-1];
        end
    end

    // The valid travels the full M-1 stages; an accepted start flushes it so
    // stragglers from before the job cannot be counted into the new one.
    if (M > 1) begin : g_vld
        logic [M-2:0] vld_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_q <= '0;
            end else if (start_acc) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= y_valid;
                for (int k = 1; k <= M - 2; k++) vld_q[k] <= vld_q[k-1];
            end
        end
        assign aligned_vld = vld_q[M-2];
    end else begin : g_vld_pass
        assign aligned_vld = y_valid;
    end

    // ------------------------------------------------------------------ fifo
    logic collecting;
    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic is_last;
    logic ovf_evt;
    logic [VW:0] head;

    assign collecting = (state_q == S_COLLECT);
    assign full       = (count_q == DEPTH_C);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign push_req   = collecting && aligned_vld;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign push       = push_req && (!full || pop);
    assign ovf_evt    = push_req && full && !pop;
    assign is_last    = (wr_cnt_q == (nv_q - CNT_W'(1)));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + OW'(1);
        end else if (!push && pop) begin
            count_d = count_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {is_last, aligned_word};
    end

    assign head     = mem_q[rd_ptr_q];
    // Masked while empty so the head never shows stale or uninitialised data.
    assign out_data = out_valid ? head[VW-1:0] : '0;
    assign out_last = out_valid && head[VW];

    // ------------------------------------------------------------------- fsm
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            nv_q       <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nv_q       <= num_vectors;
                        wr_cnt_q   <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (num_vectors == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    // Dropped vectors still count so the job always ends.
                    if (aligned_vld) begin
                        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                        if (ovf_evt) overflow_q <= 1'b1;
                        if (is_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Looking at the next occupancy makes done land right after the final pop.
                    if (count_d == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // At most M vectors can be in flight once upstream reacts, so M free
    // entries are always enough headroom.
    assign stall_req = collecting && ((DEPTH_C - count_q) <= M_C);
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/mxu_result_collector.md
# mxu_result_collector

Output-side companion of the MXU systolic core. It receives the skewed per-row result lanes `y` leaving the last column of the MAC array and realigns them into whole result vectors. It buffers the vectors in a small FIFO and hands them to the downstream writer over a valid/ready handshake. It also raises a stall request early enough that results still in flight in the skew pipeline are never lost, and it signals completion once the programmed number of vectors has been delivered.

## Interface
- `M`, 3, number of array rows = number of result lanes
- `max_data_width`, 4, bits per lane (divisor of 64)
- `DEPTH`, 8, FIFO entries, power of two, must be > M
- `CNT_W`, 16, width of vector counters
- `clk` in 1, single clock; all logic rising-edge
- `reset` in 1, asynchronous, active-low (0 = reset)
- `start` in 1, one-cycle pulse; latches `num_vectors`, clears counters, deskew valid pipe and flags
- `num_vectors` in CNT_W, number of result vectors expected for this job
- `y` in M*max_data_width, result lanes from the core; lane i = bits [(i+1)*max_data_width-1 : i*max_data_width]
- `y_valid` in 1, lane 0 of a result vector is valid this cycle; lane i of the same vector arrives i cycles later
- `out_data` out M*max_data_width, realigned vector, FIFO head
- `out_valid` out 1, FIFO non-empty
- `out_ready` in 1, downstream accepts
- `out_last` out 1, head entry is the `num_vectors`-th vector
- `stall_req` out 1, upstream must stop issuing input vectors to the core
- `busy` out 1, state ≠ IDLE
- `done` out 1, one-cycle pulse at job end
- `overflow` out 1, sticky; aligned vector arrived with the FIFO full and no simultaneous pop

## Operation
- Deskew: lane i passes through a register chain of M-1-i stages; lane M-1 passes straight through. `y_valid` passes through M-1 stages. The aligned word and aligned valid therefore coincide.
- FSM states are IDLE, COLLECT, DRAIN and DONE.
  - IDLE: `start` moves to COLLECT. If `num_vectors`==0, it moves to DONE instead.
  - COLLECT: each aligned valid pushes {last, word} into the FIFO and increments `wr_cnt`. `last` = (`wr_cnt`==`num_vectors`-1). The push with `last`=1 moves to DRAIN.
  - DRAIN: aligned valids are ignored. When the FIFO is empty, move to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Aligned valids in IDLE, DRAIN or DONE are discarded and do not count as overflow.
- `start` while not IDLE is ignored.
- Handshake: pop when `out_valid`&&`out_ready`. `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Full FIFO: a push in the same cycle as a pop succeeds. Otherwise the push is dropped, `overflow` is set, and `wr_cnt` still increments so the job terminates.
- `stall_req` = COLLECT && (free entries ≤ M), where free entries = DEPTH − occupancy. It is combinational from the registered occupancy. Honouring it within one cycle guarantees no overflow, because at most M vectors are in flight in the skew pipeline.
- Counter arithmetic is unsigned CNT_W and does not wrap within a job, since `num_vectors` ≤ 2^CNT_W−1.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `stall_req`=0, `busy`=0, `done`=0, `overflow`=0, `out_data`=0. State IDLE, FIFO empty, deskew registers 0.
- Latency: `y_valid` at cycle t → FIFO push at edge t+M-1 → `out_valid`=1 at t+M with empty FIFO.
- Throughput: one vector per cycle, in and out.
- `done` asserts the cycle after the last pop. `busy` falls together with `done`.
- Reset mid-job: everything returns to its reset values immediately. The FIFO contents and the partial count are lost.

## Test plan
- Basic, M=3, W=4: `start` with `num_vectors`=2, `out_ready`=1. Drive `y_valid` at t0 with lane0=1, lane1=2 at t0+1, lane2=3 at t0+2, and the next vector lanes = 4, 5, 6 one cycle later each. Required: `out_data`=0x321 at t0+3, then 0x654 with `out_last`=1 at t0+4, `done` at t0+5.
- Backpressure, DEPTH=8: `out_ready`=0, `num_vectors`=8, continuous `y_valid`. Required: `stall_req`=1 once occupancy reaches 5. When the source stops on that cycle, the FIFO fills to exactly 8 with `overflow`=0. Raising `out_ready` then drains 8 words in order.
- Overflow: ignore `stall_req` and push a 9th vector with `out_ready`=0. Required: `overflow`=1 and stays 1, the 9th word is absent, and the FIFO order is intact.
- Full plus simultaneous pop: with the FIFO full, `out_ready`=1 and an aligned push in the same cycle. Required: occupancy stays 8 and `overflow`=0.
- `num_vectors`=0: `start`. Required: `done` pulses the next cycle, `out_valid` never rises.
- Reset mid-job: assert `reset`=0 after 3 of 6 vectors. Required: all outputs are at their reset values asynchronously. A fresh `start` with 2 vectors then completes normally.
